// File: rtl/shift_reg_univ_if.sv
// Control, data and status bundle for the universal shift register.
// The master modport drives the inputs and the slave modport is the register side.
interface shift_reg_univ_if #(
    parameter int N = 8
);
    localparam int CW = $clog2(N + 1);

    logic          en;
    logic [2:0]    mode;
    logic          SI_R;
    logic          SI_L;
    logic [N-1:0]  d;
    logic          start;
    logic [CW-1:0] len;
    logic [N-1:0]  q;
    logic          SO_R;
    logic          SO_L;
    logic          busy;
    logic          done;

    modport master (
        output en, mode, SI_R, SI_L, d, start, len,
        input  q, SO_R, SO_L, busy, done
    );

    modport slave (
        input  en, mode, SI_R, SI_L, d, start, len,
        output q, SO_R, SO_L, busy, done
    );
endinterface

// File: rtl/shift_reg_univ.sv
// N-bit universal shift register: shift/rotate/arithmetic shift/load/clear,
// plus an autonomous burst mode that loads a word and right-shifts it len times.
module shift_reg_univ #(
    parameter int N = 8
) (
    input logic            clk,
    input logic            rst,
    shift_reg_univ_if.slave bus
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  q_q, q_d;
    logic [CW-1:0] count_q, count_d;
    logic          done_q, done_d;
    logic [CW-1:0] len_c;

    // Burst lengths beyond the register width saturate to a full-width shift-out.
    assign len_c = (bus.len > CW'(N)) ? CW'(N) : bus.len;

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        count_d = count_q;
        done_d  = 1'b0;
        if (bus.en) begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        q_d     = bus.d;
                        count_d = len_c;
                        if (len_c == '0) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = BURST;
                        end
                    end else begin
                        case (bus.mode)
                            3'b000: q_d = q_q;
                            3'b001: q_d = {bus.SI_R, q_q[N-1:1]};
                            3'b010: q_d = {q_q[N-2:0], bus.SI_L};
                            3'b011: q_d = {q_q[0], q_q[N-1:1]};
                            3'b100: q_d = {q_q[N-2:0], q_q[N-1]};
                            3'b101: q_d = bus.d;
                            3'b110: q_d = {q_q[N-1], q_q[N-1:1]};
                            3'b111: q_d = '0;
                        endcase
                    end
                end
                BURST: begin
                    q_d     = {bus.SI_R, q_q[N-1:1]};
                    count_d = count_q - CW'(1);
                    if (count_q == CW'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            q_q     <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    assign bus.q    = q_q;
    assign bus.SO_R = q_q[0];
    assign bus.SO_L = q_q[N-1];
    assign bus.busy = (state_q == BURST);
    assign bus.done = done_q;
endmodule

// File: tb/tb_shift_reg_univ.sv
// Directed bench for shift_reg_univ (N=8): modes, burst, pause, clamp, abort, back-to-back.
module tb_shift_reg_univ;
    localparam int N = 8;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    shift_reg_univ_if #(.N(N)) bus ();

    shift_reg_univ #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_st(input string tag, input logic [7:0] eq, input logic eb, input logic ed);
        chk({tag, ".q"}, 32'(bus.q), 32'(eq));
        chk({tag, ".busy"}, 32'(bus.busy), 32'(eb));
        chk({tag, ".done"}, 32'(bus.done), 32'(ed));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        // Reset with junk inputs, checked before any clock edge
        rst       = 1'b1;
        bus.en    = 1'b1;
        bus.mode  = 3'b111;
        bus.SI_R  = 1'b1;
        bus.SI_L  = 1'b1;
        bus.d     = 8'hFF;
        bus.start = 1'b1;
        bus.len   = 4'd5;
        #2;
        chk_st("reset", 8'h00, 1'b0, 1'b0);
        #4;
        rst       = 1'b0;
        bus.start = 1'b0;
        bus.mode  = 3'b000;

        // Mode walk
        bus.mode = 3'b101; bus.d = 8'hB4; step();
        chk("load", 32'(bus.q), 32'hB4);
        chk("load.SO_R", 32'(bus.SO_R), 32'h0);
        chk("load.SO_L", 32'(bus.SO_L), 32'h1);
        bus.mode = 3'b001; bus.SI_R = 1'b1; step(); chk("shr", 32'(bus.q), 32'hDA);
        bus.mode = 3'b010; bus.SI_L = 1'b0; step(); chk("shl", 32'(bus.q), 32'hB4);
        bus.mode = 3'b011; step(); chk("rotr", 32'(bus.q), 32'h5A);
        bus.mode = 3'b100; step(); chk("rotl", 32'(bus.q), 32'hB4);
        bus.mode = 3'b110; step(); chk("asr", 32'(bus.q), 32'hDA);
        bus.mode = 3'b000; step(); chk("hold", 32'(bus.q), 32'hDA);
        bus.en = 1'b0; bus.mode = 3'b111; step(); chk_st("en0", 8'hDA, 1'b0, 1'b0);
        bus.en = 1'b1; step(); chk("clear", 32'(bus.q), 32'h00);

        // Burst len=3; mode set to clear to show it is ignored while busy
        bus.mode = 3'b000; bus.d = 8'hA5; bus.len = 4'd3; bus.SI_R = 1'b0; bus.start = 1'b1;
        step(); chk_st("b3.0", 8'hA5, 1'b1, 1'b0); chk("b3.0.SO_R", 32'(bus.SO_R), 32'h1);
        bus.start = 1'b0; bus.mode = 3'b111;
        step(); chk_st("b3.1", 8'h52, 1'b1, 1'b0); chk("b3.1.SO_R", 32'(bus.SO_R), 32'h0);
        step(); chk_st("b3.2", 8'h29, 1'b1, 1'b0); chk("b3.2.SO_R", 32'(bus.SO_R), 32'h1);
        bus.mode = 3'b000;
        step(); chk_st("b3.3", 8'h14, 1'b0, 1'b1); chk("b3.3.SO_R", 32'(bus.SO_R), 32'h0);
        step(); chk_st("b3.after", 8'h14, 1'b0, 1'b0);

        // Burst len=4 with a two-cycle pause
        bus.d = 8'hF0; bus.len = 4'd4; bus.SI_R = 1'b1; bus.start = 1'b1;
        step(); chk_st("p.0", 8'hF0, 1'b1, 1'b0);
        bus.start = 1'b0;
        step(); chk_st("p.1", 8'hF8, 1'b1, 1'b0);
        step(); chk_st("p.2", 8'hFC, 1'b1, 1'b0);
        bus.en = 1'b0;
        step(); chk_st("p.hold1", 8'hFC, 1'b1, 1'b0);
        step(); chk_st("p.hold2", 8'hFC, 1'b1, 1'b0);
        bus.en = 1'b1;
        step(); chk_st("p.3", 8'hFE, 1'b1, 1'b0);
        step(); chk_st("p.4", 8'hFF, 1'b0, 1'b1);

        // len=0: load and done on the same edge, never busy
        bus.d = 8'h3C; bus.len = 4'd0; bus.start = 1'b1;
        step(); chk_st("l0", 8'h3C, 1'b0, 1'b1);
        bus.start = 1'b0;
        step(); chk_st("l0.after", 8'h3C, 1'b0, 1'b0);

        // len=15 clamps to 8 shifts
        bus.d = 8'h81; bus.len = 4'd15; bus.SI_R = 1'b0; bus.start = 1'b1;
        step(); chk_st("l15.0", 8'h81, 1'b1, 1'b0);
        bus.start = 1'b0;
        for (int i = 0; i < 7; i++) step();
        chk_st("l15.7", 8'h01, 1'b1, 1'b0);
        step(); chk_st("l15.8", 8'h00, 1'b0, 1'b1);
        step(); chk_st("l15.after", 8'h00, 1'b0, 1'b0);

        // Abort mid-burst with asynchronous reset
        bus.d = 8'hA5; bus.len = 4'd4; bus.start = 1'b1;
        step(); chk_st("ab.0", 8'hA5, 1'b1, 1'b0);
        bus.start = 1'b0;
        step(); chk_st("ab.1", 8'h52, 1'b1, 1'b0);
        rst = 1'b1; #1;
        chk_st("ab.rst", 8'h00, 1'b0, 1'b0);
        step(); rst = 1'b0;
        chk_st("ab.held", 8'h00, 1'b0, 1'b0);
        step(); chk_st("ab.nodone", 8'h00, 1'b0, 1'b0);
        bus.d = 8'h0F; bus.len = 4'd1; bus.start = 1'b1;
        step(); chk_st("ab.restart", 8'h0F, 1'b1, 1'b0);
        bus.start = 1'b0;
        step(); chk_st("ab.fin", 8'h07, 1'b0, 1'b1);

        // Back-to-back: new start while done is high
        bus.d = 8'hC3; bus.len = 4'd2; bus.start = 1'b1;
        step(); chk_st("bb.0", 8'hC3, 1'b1, 1'b0);
        bus.start = 1'b0;
        step(); chk_st("bb.1", 8'h61, 1'b1, 1'b0);
        step(); chk_st("bb.2", 8'h30, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
